// File: rtl/capture_ctrl.sv
// Acquisition/trigger controller: streams ADC samples into a circular buffer through RAM port A,
// keeps a pre-trigger history, detects a level/slope or forced trigger, fills the post-trigger part.
module capture_ctrl #(
    parameter int addr_width = 15,
    parameter int data_width = 12
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  sample_valid,
    input  logic [data_width-1:0] sample,
    input  logic [data_width-1:0] trig_level,
    input  logic                  trig_slope,
    input  logic [addr_width-1:0] pretrig,
    input  logic                  arm,
    input  logic                  force_trig,
    output logic                  wr_en,
    output logic [addr_width-1:0] wr_addr,
    output logic [data_width-1:0] wr_data,
    output logic [addr_width-1:0] trig_addr,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;

    localparam logic [addr_width-1:0] LAST = '1;
    localparam logic [addr_width-1:0] ONE  = addr_width'(1);

    state_t                state_q, state_d;
    logic [addr_width-1:0] ptr_q, ptr_d;
    logic [addr_width-1:0] pre_lat_q, pre_lat_d;
    logic [addr_width-1:0] cnt_q, cnt_d;
    logic [data_width-1:0] prev_q, prev_d;
    logic                  prev_valid_q, prev_valid_d;
    logic                  force_pending_q, force_pending_d;
    logic [addr_width-1:0] trig_addr_q, trig_addr_d;
    logic                  wr_en_q, wr_en_d;
    logic [addr_width-1:0] wr_addr_q, wr_addr_d;
    logic [data_width-1:0] wr_data_q, wr_data_d;

    logic active;
    logic level_hit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            pre_lat_q       <= '0;
            cnt_q           <= '0;
            prev_q          <= '0;
            prev_valid_q    <= 1'b0;
            force_pending_q <= 1'b0;
            trig_addr_q     <= '0;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            pre_lat_q       <= pre_lat_d;
            cnt_q           <= cnt_d;
            prev_q          <= prev_d;
            prev_valid_q    <= prev_valid_d;
            force_pending_q <= force_pending_d;
            trig_addr_q     <= trig_addr_d;
            wr_en_q         <= wr_en_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        pre_lat_d       = pre_lat_q;
        cnt_d           = cnt_q;
        prev_d          = prev_q;
        prev_valid_d    = prev_valid_q;
        trig_addr_d     = trig_addr_q;
        wr_en_d         = 1'b0;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;

        active          = (state_q == PRE) || (state_q == WAIT) || (state_q == POST);
        force_pending_d = force_pending_q | (force_trig & active);

        // The first sample after arm has no predecessor, so it can never cross on level.
        if (trig_slope)
            level_hit = prev_valid_q && (prev_q > trig_level) && (sample <= trig_level);
        else
            level_hit = prev_valid_q && (prev_q < trig_level) && (sample >= trig_level);

        if (arm) begin
            pre_lat_d       = pretrig;
            ptr_d           = '0;
            cnt_d           = '0;
            prev_valid_d    = 1'b0;
            force_pending_d = 1'b0;
            state_d         = (pretrig == '0) ? WAIT : PRE;
        end else if (sample_valid && active) begin
            wr_en_d      = 1'b1;
            wr_addr_d    = ptr_q;
            wr_data_d    = sample;
            ptr_d        = ptr_q + ONE;
            prev_d       = sample;
            prev_valid_d = 1'b1;
            case (state_q)
                PRE: begin
                    cnt_d = cnt_q + ONE;
                    if (cnt_d == pre_lat_q)
                        state_d = WAIT;
                end
                WAIT: begin
                    if (force_pending_q || level_hit) begin
                        trig_addr_d     = ptr_q;
                        force_pending_d = 1'b0;
                        cnt_d           = LAST - pre_lat_q;
                        state_d         = (cnt_d == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    cnt_d = cnt_q - ONE;
                    if (cnt_q == ONE)
                        state_d = DONE;
                end
                default: ;
            endcase
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign trig_addr = trig_addr_q;
    assign busy      = (state_q == PRE) || (state_q == WAIT) || (state_q == POST);
    assign done      = (state_q == DONE);

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
Acquisition/trigger controller that sits directly upstream of the sample dual-port RAM and drives its port A write side. It accepts a stream of ADC samples, keeps a programmable pre-trigger history in the circular buffer, detects a level/slope trigger (or a forced trigger), fills the post-trigger portion, then stops and reports done. The display/readout logic on port B uses trig_addr to locate the trigger sample.

Parameters:
addr_width, 15, buffer address width; depth N = 2**addr_width samples
data_width, 12, ADC sample width (unsigned)

Ports:
clock  in  1  system clock
reset_n  in  1  reset
sample_valid  in  1  qualifies sample for one cycle
sample  in  data_width  ADC sample, unsigned
trig_level  in  data_width  trigger threshold, unsigned
trig_slope  in  1  0 = rising, 1 = falling
pretrig  in  addr_width  samples kept before trigger (0..N-1)
arm  in  1  single-cycle start/restart pulse
force_trig  in  1  single-cycle forced-trigger request
wr_en  out  1  RAM port A write enable
wr_addr  out  addr_width  RAM port A address
wr_data  out  data_width  RAM port A write data
trig_addr  out  addr_width  address holding the trigger sample
busy  out  1  capture in progress
done  out  1  buffer complete, held until next arm

Behaviour:
- One clock; reset is asynchronous and active-low (reset_n). On reset, all outputs are 0, state is IDLE, ptr/counters/prev_valid/force_pending are 0.
- States: IDLE, PRE, WAIT, POST, DONE. busy=1 in PRE/WAIT/POST; done=1 only in DONE.
- arm, in any state (including mid-capture), takes priority over all other events: it latches pretrig into pre_lat, clears ptr, prev_valid, force_pending and done, and enters PRE (or WAIT if pretrig=0). Any sample_valid in the arm cycle is discarded.
- Write path, active only in PRE/WAIT/POST: a sample_valid in cycle t produces wr_en=1, wr_data=sample, wr_addr=ptr in cycle t+1. Then ptr increments modulo N (wraps N-1 -> 0). Latency is 1 cycle. wr_en is 0 in all cycles not produced by a valid sample. There are no writes in IDLE/DONE.
- PRE: count accepted samples. When the pre_lat-th sample is accepted, go to WAIT. Trigger conditions in PRE are ignored.
- Trigger test, applied only in WAIT on a valid sample with prev_valid=1, using unsigned compares:
  - rising: prev < trig_level and sample >= trig_level.
  - falling: prev > trig_level and sample <= trig_level.
- prev is updated on every accepted sample, and prev_valid is set. The first sample after arm can never trigger on level.
- force_trig while busy sets force_pending. In WAIT, the next valid sample triggers if force_pending=1, regardless of level.
- On trigger, the triggering sample is written at ptr, and trig_addr is set to that ptr. force_pending is cleared, the post counter is loaded with N-1-pre_lat, and the state goes to POST. If that value is 0, the state goes straight to DONE.
- POST: each accepted sample decrements the counter. The sample that brings it to 0 is the last write, and the state goes to DONE on that same edge. done rises the cycle of the final wr_en.
- Total samples per completed capture after the trigger sample, trigger included: N - pre_lat. The oldest valid pre-trigger sample is at trig_addr - pre_lat mod N.
- In WAIT the buffer keeps wrapping indefinitely. Samples older than pre_lat may be overwritten; that is intended.
- trig_addr holds its value until the next trigger; it is not cleared on arm.
- Changes to trig_level and trig_slope take effect immediately. pretrig changes take effect only at arm.

Test Plan:
1. addr_width=4, pretrig=4, rising, level 0x800, arm then ramp 0x000,0x100,... one per cycle:
   - WAIT after sample 3.
   - Trigger at sample 0x800, with trig_addr=8.
   - 12 post samples at addrs 8..15,0..3.
   - done=1 with the write to addr 3, then no further wr_en.
2. Same settings, with a 0x000->0x900 crossing at samples 0/1 and no later crossing: no trigger in PRE, busy stays 1. A crossing in WAIT then triggers.
3. Falling slope, level 0x400, samples 0xFFF,0x500,0x400: trigger on 0x400. Equal-level samples with prev == level do not trigger.
4. Constant sample 0x123, force_trig pulsed during PRE: trigger occurs on the first valid sample in WAIT, and trig_addr equals pretrig.
5. sample_valid toggling 1/0: wr_en appears only one cycle after valid cycles and addresses are contiguous. Also:
   - reset_n low mid-POST clears all outputs asynchronously to 0, and the block returns to IDLE.
   - arm mid-WAIT restarts at ptr=0.
6. pretrig=0, rising trigger: WAIT immediately after arm, and the trigger is the first level-qualified crossing. N samples are written from trig_addr, and done follows.
